// File: rtl/mips_pkg.sv
// Shared MIPS instruction definitions: descriptor kinds, opcodes and field widths.
// Used by the instruction loader and the core decoder.
package mips_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;
    localparam int unsigned KIND_W   = 3;

    typedef enum logic [KIND_W-1:0] {
        RTYPE = 3'd0,
        LW    = 3'd1,
        SW    = 3'd2,
        BEQ   = 3'd3,
        ADDI  = 3'd4,
        JUMP  = 3'd5
    } kind_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_JUMP  = 6'b000010;

    // Raw kind kept as bits so the illegal codes 6-7 can be carried and detected.
    typedef struct packed {
        logic [KIND_W-1:0]   kind;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [SHAMT_W-1:0]  shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm;
        logic [TARGET_W-1:0] target;
    } instr_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational encoder: instruction descriptor -> 32-bit MIPS word plus illegal-kind flag.
module instr_pack
    import mips_pkg::*;
(
    input  instr_desc_t       i_desc,
    output logic [WORD_W-1:0] o_word,
    output logic              o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_desc.kind)
            RTYPE:   o_word = {OP_RTYPE, i_desc.rs, i_desc.rt, i_desc.rd, i_desc.shamt, i_desc.funct};
            LW:      o_word = {OP_LW,   i_desc.rs, i_desc.rt, i_desc.imm};
            SW:      o_word = {OP_SW,   i_desc.rs, i_desc.rt, i_desc.imm};
            BEQ:     o_word = {OP_BEQ,  i_desc.rs, i_desc.rt, i_desc.imm};
            ADDI:    o_word = {OP_ADDI, i_desc.rs, i_desc.rt, i_desc.imm};
            JUMP:    o_word = {OP_JUMP, i_desc.target};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: accepts instruction descriptors, encodes them and writes
// consecutive words from BASE_ADDR, tracking word count and session error flags.
module instr_loader
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [KIND_W-1:0]     in_kind,
    input  logic [REG_W-1:0]      in_rs,
    input  logic [REG_W-1:0]      in_rt,
    input  logic [REG_W-1:0]      in_rd,
    input  logic [SHAMT_W-1:0]    in_shamt,
    input  logic [FUNCT_W-1:0]    in_funct,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [TARGET_W-1:0]   in_target,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [WORD_W-1:0]     imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_overflow,
    output logic [$clog2(DEPTH):0] word_count
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned CMP_W = CW + 1;

    load_state_t        r_state;
    logic [WORD_W-1:0]  r_ptr;
    logic [WORD_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic [CW-1:0]      r_count;
    logic               r_we;
    logic               r_stop;
    logic               r_err_illegal;
    logic               r_err_overflow;

    instr_desc_t        w_desc;
    logic [WORD_W-1:0]  w_word;
    logic               w_illegal;
    logic [CMP_W-1:0]   w_fill;
    logic               w_ready;
    logic               w_accept;

    assign w_desc = '{kind:   in_kind,
                      rs:     in_rs,
                      rt:     in_rt,
                      rd:     in_rd,
                      shamt:  in_shamt,
                      funct:  in_funct,
                      imm:    in_imm,
                      target: in_target};

    instr_pack u_pack (
        .i_desc    (w_desc),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Fill level includes a write still in flight so memory can never be over-run.
    assign w_fill   = CMP_W'(r_count) + CMP_W'(r_we);
    assign w_ready  = (r_state == ST_LOAD) && !r_stop && (w_fill < CMP_W'(DEPTH));
    assign w_accept = in_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= BASE_ADDR;
            r_count        <= '0;
            r_we           <= 1'b0;
            r_stop         <= 1'b0;
            r_addr         <= BASE_ADDR;
            r_wdata        <= '0;
            r_err_illegal  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state        <= ST_LOAD;
                        r_ptr          <= BASE_ADDR;
                        r_count        <= '0;
                        r_stop         <= 1'b0;
                        r_err_illegal  <= 1'b0;
                        r_err_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_err_illegal <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_wdata <= w_word;
                            r_ptr   <= r_ptr + 32'd4;
                        end
                        if (in_last) begin
                            r_stop <= 1'b1;
                        end
                    end
                    if (r_we) begin
                        r_count <= r_count + CW'(1);
                    end
                    // Leave once the final descriptor's write (if any) is retiring, or memory fills.
                    if (r_stop) begin
                        r_state <= ST_DONE;
                    end else if (r_we && (r_count == CW'(DEPTH - 1))) begin
                        r_err_overflow <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = w_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign busy         = (r_state == ST_LOAD);
    assign done         = (r_state == ST_DONE);
    assign err_illegal  = r_err_illegal;
    assign err_overflow = r_err_overflow;
    assign word_count   = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed vectors plus randomized sessions against
// a descriptor-level reference model; a negedge monitor checks every memory write.
module tb_instr_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        busy, done, err_illegal, err_overflow;
    logic [2:0]  word_count;

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
        .word_count(word_count)
    );

    typedef struct {
        int unsigned kind, rs, rt, rd, shamt, funct, imm, target;
        bit          last;
    } d_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          m_cnt;
    bit          m_ill, m_ovf, m_end;
    logic [31:0] last_addr, last_word;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            last_addr = BASE;
            last_word = 32'h0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Monitor: every write must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (imem_we === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("write_addr", imem_addr, e.addr);
                check("write_data", imem_wdata, e.word);
                check("write_cycle", 32'(cyc), 32'(e.cyc));
                last_addr = e.addr;
                last_word = e.word;
            end
        end else begin
            check("hold_addr", imem_addr, last_addr);
            check("hold_data", imem_wdata, last_word);
        end
    end

    // Reference encoding built from field weights rather than bit concatenation.
    function automatic logic [31:0] model_word(input d_t d);
        int unsigned ops[6] = '{0, 35, 43, 4, 8, 2};
        longint unsigned w;
        if (d.kind == 0)
            w = d.rs * 2097152 + d.rt * 65536 + d.rd * 2048 + d.shamt * 64 + d.funct;
        else if (d.kind == 5)
            w = longint'(ops[5]) * 67108864 + d.target;
        else
            w = longint'(ops[d.kind]) * 67108864 + d.rs * 2097152 + d.rt * 65536 + d.imm;
        return 32'(w);
    endfunction

    function automatic d_t mk(input int unsigned kind, rs, rt, rd, shamt, funct, imm, target,
                              input bit last);
        d_t d;
        d.kind = kind; d.rs = rs; d.rt = rt; d.rd = rd; d.shamt = shamt;
        d.funct = funct; d.imm = imm; d.target = target; d.last = last;
        return d;
    endfunction

    task automatic rand_desc(output d_t d);
        int unsigned r;
        r = $urandom_range(0, 99);
        d.kind   = (r < 15) ? 6 + $urandom_range(0, 1) : $urandom_range(0, 5);
        d.rs     = $urandom_range(0, 31);
        d.rt     = $urandom_range(0, 31);
        d.rd     = $urandom_range(0, 31);
        d.shamt  = $urandom_range(0, 31);
        d.funct  = $urandom_range(0, 63);
        d.imm    = $urandom_range(0, 65535);
        d.target = $urandom_range(0, 67108863);
        d.last   = 1'b0;
    endtask

    task automatic drive(input d_t d);
        in_kind = 3'(d.kind); in_rs = 5'(d.rs); in_rt = 5'(d.rt); in_rd = 5'(d.rd);
        in_shamt = 5'(d.shamt); in_funct = 6'(d.funct); in_imm = 16'(d.imm);
        in_target = 26'(d.target); in_last = d.last;
    endtask

    // Session-level model: what an accepted descriptor must cause.
    task automatic model_accept(input d_t d, input logic [31:0] w);
        if (d.kind > 5) begin
            m_ill = 1'b1;
        end else begin
            q.push_back('{BASE + 32'(4 * m_cnt), w, cyc + 1});
            m_cnt++;
        end
        if (d.last) begin
            m_end = 1'b1;
        end else if (m_cnt == DEPTH) begin
            m_end = 1'b1;
            m_ovf = 1'b1;
        end
    endtask

    task automatic send(input d_t d, input logic [31:0] w, input int budget, output bit acc);
        drive(d);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < budget && !acc; t++) begin
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                model_accept(d, w);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic session(input d_t ds[$], input logic [31:0] ws[$], input bit gaps);
        bit acc;
        d_t pr;
        do_start();
        m_cnt = 0; m_ill = 0; m_ovf = 0; m_end = 0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_count", 32'(word_count), 0);
        check("start_errs", {err_illegal, err_overflow}, 0);
        foreach (ds[i]) begin
            if (m_end) break;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    start = ($urandom_range(0, 3) == 0);
                    rand_desc(pr);
                    drive(pr);
                    @(negedge clk);
                end
                start = 1'b0;
            end
            send(ds[i], ws[i], 1, acc);
            check("accept", 32'(acc), 1);
        end
        check("session_end", 32'(m_end), 1);
        if (!m_end) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            q.delete();
            return;
        end
        rand_desc(pr);
        drive(pr);
        in_valid = 1'b1;
        check("ready_after_end", in_ready, 0);
        check("done_early", done, 0);
        @(negedge clk);
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("ready_in_done", in_ready, 0);
        check("word_count", 32'(word_count), 32'(m_cnt));
        check("err_illegal", err_illegal, m_ill);
        check("err_overflow", err_overflow, m_ovf);
        check("queue_drained", 32'(q.size()), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        d_t          dq[$];
        logic [31:0] wq[$];
        d_t          d;
        int          n;
        bit          use_last;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        d = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(d);
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_errs", {err_illegal, err_overflow}, 0);
        check("rst_count", 32'(word_count), 0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;

        // Single R-type.
        dq = '{mk(0, 17, 18, 16, 0, 32'h20, 0, 0, 1)};
        wq = '{32'h0232_8020};
        session(dq, wq, 0);

        // Back-to-back mix ending with a jump.
        dq = '{mk(1, 0, 2, 0, 0, 0, 32'h50, 0, 0), mk(4, 0, 2, 0, 0, 0, 5, 0, 0),
               mk(3, 3, 7, 0, 0, 0, 32'hA, 0, 0),  mk(5, 0, 0, 0, 0, 0, 0, 32'h11, 1)};
        wq = '{32'h8C02_0050, 32'h2002_0005, 32'h1067_000A, 32'h0800_0011};
        session(dq, wq, 0);

        // Illegal kind mid-stream leaves no hole in the address sequence.
        dq = '{mk(1, 0, 2, 0, 0, 0, 32'h50, 0, 0), mk(6, 1, 1, 1, 1, 1, 1, 1, 0),
               mk(2, 29, 31, 0, 0, 0, 4, 0, 1)};
        wq = '{32'h8C02_0050, 32'h0, 32'hAFBF_0004};
        session(dq, wq, 0);

        // Five descriptors, no last: memory fills after four.
        dq = '{mk(4, 1, 1, 0, 0, 0, 1, 0, 0), mk(4, 1, 1, 0, 0, 0, 2, 0, 0),
               mk(4, 1, 1, 0, 0, 0, 3, 0, 0), mk(4, 1, 1, 0, 0, 0, 4, 0, 0),
               mk(4, 1, 1, 0, 0, 0, 5, 0, 0)};
        wq = '{32'h2021_0001, 32'h2021_0002, 32'h2021_0003, 32'h2021_0004, 32'h2021_0005};
        session(dq, wq, 0);

        // Reset on the accept edge drops the write; loading restarts from BASE.
        do_start();
        drive(mk(1, 4, 5, 0, 0, 0, 32'h1234, 0, 0));
        in_valid = 1'b1;
        check("pre_rst_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mid_we", imem_we, 0);
        check("rst_mid_state", {busy, done}, 0);
        check("rst_mid_count", 32'(word_count), 0);
        rst = 1'b0;
        @(negedge clk);
        dq = '{mk(2, 8, 9, 0, 0, 0, 32'h10, 0, 1)};
        wq = '{32'hAD09_0010};
        session(dq, wq, 0);

        // Randomized sessions with gaps and ignored start pulses.
        repeat (30) begin
            dq.delete();
            wq.delete();
            n = $urandom_range(1, 6);
            use_last = $urandom_range(0, 1);
            for (int i = 0; i < 12; i++) begin
                rand_desc(d);
                d.last = use_last && (i == n - 1);
                dq.push_back(d);
                wq.push_back(model_word(d));
            end
            session(dq, wq, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("final_queue", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
